// File: rtl/pwam_ctrl.sv
// pwam_ctrl: two-requester round-robin job controller for one shared pwam instance.
// Optional RUN watchdog enabled by defining PWAM_CTRL_TIMEOUT_EN.
module pwam_ctrl #(
    parameter int N_LOAD      = 256,
    parameter int N_OUT       = 128,
    parameter int OUT_DEPTH   = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        srst_n,
    input  logic [1:0]  req,
    input  logic [1:0]  req_mode,
    output logic [1:0]  gnt,
    input  logic [1:0]  in_valid,
    input  logic [63:0] in_data,
    output logic [1:0]  in_ready,
    output logic [1:0]  out_valid,
    output logic [31:0] out_data,
    input  logic [1:0]  out_ready,
    output logic [1:0]  job_done,
    output logic [2:0]  err,
    input  logic        err_clr,
    output logic        pw_srst,
    output logic        pw_mode,
    output logic        pw_start,
    output logic        pw_wea,
    output logic        pw_web,
    output logic [31:0] pw_dina,
    output logic [31:0] pw_dinb,
    input  logic        pw_valid,
    input  logic        pw_done,
    input  logic [31:0] pw_dout
);
    localparam int LW = $clog2(N_LOAD) + 1;
    localparam int RW = $clog2(N_OUT + 1) + 1;
    localparam int AW = $clog2(OUT_DEPTH);

    typedef enum logic [3:0] {IDLE, GRANT, CLR, LOAD_A, LOAD_B, START, RUN, DRAIN, REL} state_t;
    state_t state, nxt;

    logic          rr_ptr, win, own, clr_cnt;
    logic [LW-1:0] ld_cnt;
    logic [RW-1:0] res_cnt;
    logic [31:0]   mem [OUT_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [31:0]   beat;
    logic          empty, full, acc, last_beat, push, pop, ovf, cnt_bad, tmo;

    assign own       = gnt[1];
    assign win       = (req == 2'b11) ? rr_ptr : req[1];
    assign empty     = wr_ptr == rd_ptr;
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign in_ready  = (state == LOAD_A || state == LOAD_B) ? gnt : 2'b00;
    assign acc       = |(in_ready & in_valid);
    assign beat      = own ? in_data[63:32] : in_data[31:0];
    assign last_beat = acc && ld_cnt == LW'(N_LOAD - 1);
    assign out_valid = empty ? 2'b00 : gnt;
    assign out_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign pop       = |(out_valid & out_ready);
    // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
    assign push      = state == RUN && pw_valid && (!full || pop);
    assign ovf       = state == RUN && pw_valid && full && !pop;
    assign cnt_bad   = state == RUN && pw_done &&
                       (res_cnt + RW'(pw_valid && res_cnt != '1)) != RW'(N_OUT);
    assign job_done  = (state == REL) ? gnt : 2'b00;

`ifdef PWAM_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;
    logic [TW-1:0] run_cnt;
    assign tmo = state == RUN && !pw_done && run_cnt == TW'(TIMEOUT_CYC - 1);
    always_ff @(posedge clk or negedge srst_n)
        if (!srst_n) run_cnt <= '0;
        else         run_cnt <= (state == RUN) ? run_cnt + 1'b1 : '0;
`else
    assign tmo = 1'b0 && TIMEOUT_CYC > 0;
`endif

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = |req ? GRANT : IDLE;
            GRANT:   nxt = CLR;
            CLR:     nxt = clr_cnt ? LOAD_A : CLR;
            LOAD_A:  nxt = last_beat ? LOAD_B : LOAD_A;
            LOAD_B:  nxt = last_beat ? START : LOAD_B;
            START:   nxt = RUN;
            RUN:     nxt = tmo ? REL : pw_done ? DRAIN : RUN;
            DRAIN:   nxt = empty ? REL : DRAIN;
            REL:     nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            pw_mode  <= 1'b0;
            rr_ptr   <= 1'b0;
            clr_cnt  <= 1'b0;
            ld_cnt   <= '0;
            pw_srst  <= 1'b1;
            pw_wea   <= 1'b0;
            pw_web   <= 1'b0;
            pw_dina  <= '0;
            pw_dinb  <= '0;
            pw_start <= 1'b0;
            res_cnt  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            err      <= '0;
        end else begin
            state    <= nxt;
            gnt      <= (state == GRANT) ? (win ? 2'b10 : 2'b01) : (state == REL) ? 2'b00 : gnt;
            pw_mode  <= (state == GRANT) ? req_mode[win] : pw_mode;
            rr_ptr   <= (state == REL) ? ~own : rr_ptr;
            clr_cnt  <= (state == CLR) ? ~clr_cnt : 1'b0;
            ld_cnt   <= last_beat ? '0 : acc ? ld_cnt + 1'b1 : ld_cnt;
            pw_srst  <= nxt == CLR;
            pw_wea   <= state == LOAD_A && acc;
            pw_web   <= state == LOAD_B && acc;
            pw_dina  <= (state == LOAD_A && acc) ? beat : pw_dina;
            pw_dinb  <= (state == LOAD_B && acc) ? beat : pw_dinb;
            pw_start <= state == START;
            res_cnt  <= (state == GRANT) ? '0 :
                        (state == RUN && pw_valid && res_cnt != '1) ? res_cnt + 1'b1 : res_cnt;
            // Timeout discards whatever results are still buffered.
            wr_ptr   <= tmo ? '0 : push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr   <= tmo ? '0 : pop ? rd_ptr + 1'b1 : rd_ptr;
            err      <= err_clr ? '0 : err | {tmo, cnt_bad, ovf};
        end
    end

    always_ff @(posedge clk)
        if (push) mem[wr_ptr[AW-1:0]] <= pw_dout;
endmodule
